shift_add_mul_ctrl: RTL

//  Sequencer for the 16-bit left shifter. Performs a 16x16 unsigned shift-and-add multiply

---
 rtl/shift_add_mul_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle 16x16 shift-and-add multiplier (low 16-bit result) built around a 16-bit left shifter.
// Optional early termination is enabled with `define MUL_EARLY_EXIT_EN.

module left_shift_16bit (
  input  logic [15:0] i_data,
  input  logic [3:0]  i_shift,
  output logic [15:0] o_data
);
  assign o_data = i_data << i_shift;
endmodule

module shift_add_mul_ctrl #(
  parameter int WIDTH      = 16,
  parameter bit SAT_ON_OVF = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod,
  output logic             out_ovf,
  output logic             busy,
  output logic [3:0]       shift_sel
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [3:0]       r_idx;
  logic             r_ovf;
  logic [WIDTH-1:0] r_prod;
  logic             r_prod_ovf;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_lost_bits;
  logic [WIDTH:0]   w_sum;
  logic             w_bit;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_ovf_nxt;
  logic             w_last;

  left_shift_16bit u_shifter (
    .i_data  (r_a),
    .i_shift (r_idx),
    .o_data  (w_shifted)
  );

  // Bits of the multiplicand pushed past bit 15 by the current shift amount.
  assign w_lost_bits = r_a >> (5'd16 - {1'b0, r_idx});
  assign w_bit       = r_b[r_idx];
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_shifted};
  assign w_acc_nxt   = w_bit ? w_sum[WIDTH-1:0] : r_acc;
  assign w_ovf_nxt   = r_ovf | (w_bit & (w_sum[WIDTH] | (|w_lost_bits)));

`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0] w_upper;
  assign w_upper = (r_b >> r_idx) >> 1;
  assign w_last  = (r_idx == 4'd15) || (w_upper == '0);
`else
  assign w_last  = (r_idx == 4'd15);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    shift_sel   = 4'd0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        shift_sel = r_idx;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_idx      <= 4'd0;
      r_ovf      <= 1'b0;
      r_prod     <= '0;
      r_prod_ovf <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= '0;
            r_idx <= 4'd0;
            r_ovf <= 1'b0;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_ovf <= w_ovf_nxt;
          r_idx <= w_last ? 4'd0 : r_idx + 4'd1;
          if (w_last) begin
            r_prod     <= (SAT_ON_OVF && w_ovf_nxt) ? {WIDTH{1'b1}} : w_acc_nxt;
            r_prod_ovf <= w_ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_prod = r_prod;
  assign out_ovf  = r_prod_ovf;

endmodule
